// File: rtl/dac_spi_scheduler.sv
// Round-robin scheduler sharing one DAC SPI link between N_REQ word requesters.
// Each word goes out MSB-first as {channel addr, data}; LDAC pulses run between words.
module dac_spi_scheduler #(
    parameter int N_REQ        = 2,
    parameter int DATA_W       = 12,
    parameter int ADDR_W       = 4,
    parameter int SCLK_DIV     = 4,
    parameter int LATCH_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    input  logic                    latch_req,
    output logic                    dac_csn,
    output logic                    dac_sclk,
    output logic                    dac_mosi,
    output logic                    dac_latchn,
    output logic                    busy,
    output logic [1:0]              grant_id
);

    localparam int W      = ADDR_W + DATA_W;
    localparam int HALVES = 2 * W + 1;
    localparam int HALF_W = $clog2(HALVES + 1);
    localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int LAT_W  = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ARB, S_SHIFT, S_GAP, S_LATCH} state_t;

    state_t              state_q, state_d;
    logic [1:0]          rr_q, rr_d;
    logic [1:0]          grant_q, grant_d;
    logic                pend_q, pend_d;
    logic                csn_q, csn_d;
    logic                sclk_q, sclk_d;
    logic                latchn_q, latchn_d;
    logic [W-1:0]        shreg_q, shreg_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [HALF_W-1:0]   half_q, half_d;
    logic [LAT_W-1:0]    lat_q, lat_d;

    logic [3:0]          valid_pad;
    logic [DATA_W-1:0]   data_arr [4];
    logic                found;
    logic [1:0]          win;
    logic [2:0]          cand;
    logic [1:0]          rr_next;
    logic [W-1:0]        word_sel;
    logic                div_end;

    // Unused requester slots read as idle with zero data so the arbiter can use fixed 2-bit indices.
    assign valid_pad = 4'(req_valid);
    for (genvar gi = 0; gi < 4; gi++) begin : g_data
        if (gi < N_REQ) begin : g_used
            assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
        end else begin : g_unused
            assign data_arr[gi] = '0;
        end
    end

    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr_q} + 3'(k);
            if (cand >= 3'(N_REQ)) begin
                cand = cand - 3'(N_REQ);
            end
            if (!found && valid_pad[cand[1:0]]) begin
                found = 1'b1;
                win   = cand[1:0];
            end
        end
    end

    assign rr_next  = (win == 2'(N_REQ - 1)) ? 2'd0 : win + 2'd1;
    assign word_sel = {ADDR_W'(win), data_arr[win]};
    assign div_end  = (div_q == DIV_W'(SCLK_DIV - 1));

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_ready[gi] = (state_q == S_ARB) && found && (win == 2'(gi));
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        pend_d   = pend_q | latch_req;
        csn_d    = csn_q;
        sclk_d   = sclk_q;
        latchn_d = latchn_q;
        shreg_d  = shreg_q;
        div_d    = div_q;
        half_d   = half_q;
        lat_d    = lat_q;
        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    state_d  = S_LATCH;
                    pend_d   = 1'b0;
                    latchn_d = 1'b0;
                    lat_d    = '0;
                end else if (|req_valid) begin
                    state_d = S_ARB;
                end
            end
            S_ARB: begin
                // A requester that withdrew since IDLE simply yields no grant.
                if (found) begin
                    shreg_d = word_sel;
                    csn_d   = 1'b0;
                    sclk_d  = 1'b0;
                    grant_d = win;
                    rr_d    = rr_next;
                    div_d   = '0;
                    half_d  = '0;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                // Half 0 is setup, odd halves are sclk high, even halves low; the last low half ends the frame.
                if (div_end) begin
                    div_d  = '0;
                    half_d = half_q + 1'b1;
                    if (half_q == HALF_W'(HALVES - 1)) begin
                        csn_d   = 1'b1;
                        sclk_d  = 1'b0;
                        shreg_d = '0;
                        state_d = S_GAP;
                    end else if (!half_q[0]) begin
                        sclk_d = 1'b1;
                    end else begin
                        sclk_d  = 1'b0;
                        shreg_d = shreg_q << 1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_GAP: begin
                if (div_end) begin
                    div_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (lat_q == LAT_W'(LATCH_CYCLES - 1)) begin
                    latchn_d = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            pend_q   <= 1'b0;
            csn_q    <= 1'b1;
            sclk_q   <= 1'b0;
            latchn_q <= 1'b1;
            shreg_q  <= '0;
            div_q    <= '0;
            half_q   <= '0;
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            pend_q   <= pend_d;
            csn_q    <= csn_d;
            sclk_q   <= sclk_d;
            latchn_q <= latchn_d;
            shreg_q  <= shreg_d;
            div_q    <= div_d;
            half_q   <= half_d;
            lat_q    <= lat_d;
        end
    end

    // MOSI is the shift register MSB; it empties to zero after the last bit.
    assign dac_csn    = csn_q;
    assign dac_sclk   = sclk_q;
    assign dac_mosi   = shreg_q[W-1];
    assign dac_latchn = latchn_q;
    assign busy       = (state_q != S_IDLE) || pend_q;
    assign grant_id   = grant_q;

endmodule

// File: tb/tb_dac_spi_scheduler.sv
// Directed bench for dac_spi_scheduler: default instance plus a 3-requester, SCLK_DIV=1 instance.
module tb_dac_spi_scheduler;

    logic clk;
    initial clk = 1'b0;
    always #10 clk = ~clk;

    logic        rst_n;
    logic [1:0]  va;
    logic [23:0] da;
    logic [1:0]  a_ready;
    logic        la, a_csn, a_sclk, a_mosi, a_latchn, a_busy;
    logic [1:0]  a_gid;
    logic [2:0]  vb;
    logic [35:0] db;
    logic [2:0]  b_ready;
    logic        lb, b_csn, b_sclk, b_mosi, b_latchn, b_busy;
    logic [1:0]  b_gid;

    dac_spi_scheduler u_dut_a (
        .clk(clk), .reset_n(rst_n), .req_valid(va), .req_data(da), .req_ready(a_ready),
        .latch_req(la), .dac_csn(a_csn), .dac_sclk(a_sclk), .dac_mosi(a_mosi),
        .dac_latchn(a_latchn), .busy(a_busy), .grant_id(a_gid)
    );

    dac_spi_scheduler #(.N_REQ(3), .SCLK_DIV(1)) u_dut_b (
        .clk(clk), .reset_n(rst_n), .req_valid(vb), .req_data(db), .req_ready(b_ready),
        .latch_req(lb), .dac_csn(b_csn), .dac_sclk(b_sclk), .dac_mosi(b_mosi),
        .dac_latchn(b_latchn), .busy(b_busy), .grant_id(b_gid)
    );

    logic csn_w [2];
    logic sclk_w [2];
    logic mosi_w [2];
    logic latchn_w [2];
    logic [2:0] rdy_w [2];
    assign csn_w[0] = a_csn;       assign csn_w[1] = b_csn;
    assign sclk_w[0] = a_sclk;     assign sclk_w[1] = b_sclk;
    assign mosi_w[0] = a_mosi;     assign mosi_w[1] = b_mosi;
    assign latchn_w[0] = a_latchn; assign latchn_w[1] = b_latchn;
    assign rdy_w[0] = {1'b0, a_ready};
    assign rdy_w[1] = b_ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Per-frame records captured by the bus monitor; the stimulus only reads them.
    logic [15:0] rec_word [2][32];
    int rec_bits [2][32];
    int rec_len  [2][32];
    int rec_fall [2][32];
    int rec_rise [2][32];
    int rec_per  [2][32];
    int rec_n [2];
    int cur_bits [2];
    int cur_len [2];
    int cur_fall [2];
    int cur_r0 [2];
    int cur_per [2];
    logic [15:0] cur_word [2];
    logic csn_prev [2];
    logic sclk_prev [2];
    logic latchn_prev [2];
    int lat_n [2];
    int lat_start [2];
    int lat_len [2];
    int overlap [2];
    int oh_err [2];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            rec_n[k] = 0; cur_bits[k] = 0; cur_len[k] = 0; cur_fall[k] = 0; cur_r0[k] = 0;
            cur_per[k] = 0; cur_word[k] = '0; csn_prev[k] = 1'b1; sclk_prev[k] = 1'b0;
            latchn_prev[k] = 1'b1; lat_n[k] = 0; lat_start[k] = 0; lat_len[k] = 0;
            overlap[k] = 0; oh_err[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (csn_w[k] === 1'b0) begin
                    if (csn_prev[k]) begin
                        cur_bits[k] = 0; cur_len[k] = 0; cur_word[k] = '0;
                        cur_fall[k] = cyc; cur_per[k] = 0;
                    end
                    cur_len[k]++;
                    if (sclk_w[k] && !sclk_prev[k]) begin
                        cur_word[k] = {cur_word[k][14:0], mosi_w[k]};
                        if (cur_bits[k] == 0) cur_r0[k] = cyc;
                        if (cur_bits[k] == 1) cur_per[k] = cyc - cur_r0[k];
                        cur_bits[k]++;
                    end
                end else if (!csn_prev[k] && rec_n[k] < 32) begin
                    rec_word[k][rec_n[k]] = cur_word[k];
                    rec_bits[k][rec_n[k]] = cur_bits[k];
                    rec_len[k][rec_n[k]]  = cur_len[k];
                    rec_fall[k][rec_n[k]] = cur_fall[k];
                    rec_rise[k][rec_n[k]] = cyc;
                    rec_per[k][rec_n[k]]  = cur_per[k];
                    $display("dut%0d frame %0d: word 0x%04h bits %0d csn_low %0d cycles", k, rec_n[k],
                             cur_word[k], cur_bits[k], cur_len[k]);
                    rec_n[k]++;
                end
                if (latchn_w[k] === 1'b0) begin
                    if (latchn_prev[k]) begin
                        lat_n[k]++;
                        lat_start[k] = cyc;
                        lat_len[k] = 0;
                    end
                    lat_len[k]++;
                    if (csn_w[k] === 1'b0) overlap[k]++;
                end
                if ((rdy_w[k] & (rdy_w[k] - 3'd1)) != 3'd0) oh_err[k]++;
                csn_prev[k]    = (csn_w[k] !== 1'b0);
                sclk_prev[k]   = (sclk_w[k] === 1'b1);
                latchn_prev[k] = (latchn_w[k] !== 1'b0);
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_grant(input int k, output int idx, output logic [2:0] vec);
        idx = -1;
        vec = '0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (rdy_w[k] != 3'd0) begin
                vec = rdy_w[k];
                break;
            end
        end
        if (vec != 3'd0) begin
            for (int b = 2; b >= 0; b--) if (vec[b]) idx = b;
            $display("dut%0d grant to requester %0d (ready=%b)", k, idx, vec);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_words(input int k, input int target);
        for (int n = 0; n < 2000 && rec_n[k] < target; n++) @(negedge clk);
        check_val("frames_seen", 32'(rec_n[k] >= target), 32'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; va = '0; vb = '0; la = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx, base, lbase;
        logic [2:0] vec;
        logic hit;
        rst_n = 1'b0; va = '0; vb = '0; la = 1'b0; lb = 1'b0;
        da = {12'h123, 12'hABC};
        db = {12'h333, 12'h222, 12'h111};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_csn", 32'(a_csn), 32'd1);
        check_val("rst_sclk", 32'(a_sclk), 32'd0);
        check_val("rst_mosi", 32'(a_mosi), 32'd0);
        check_val("rst_latchn", 32'(a_latchn), 32'd1);
        check_val("rst_ready", 32'(a_ready), 32'd0);
        check_val("rst_busy", 32'(a_busy), 32'd0);
        check_val("rst_gid", 32'(a_gid), 32'd0);
        check_val("rst_b_csn", 32'(b_csn), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single word from requester 0
        base = rec_n[0];
        va = 2'b01;
        wait_grant(0, idx, vec);
        check_val("t2_grant", 32'(idx), 32'd0);
        check_val("t2_ready", 32'(vec), 32'd1);
        va = 2'b00;
        wait_words(0, base + 1);
        check_val("t2_word", 32'(rec_word[0][base]), 32'h0ABC);
        check_val("t2_bits", 32'(rec_bits[0][base]), 32'd16);
        check_val("t2_csn_low", 32'(rec_len[0][base]), 32'd132);
        check_val("t2_gid", 32'(a_gid), 32'd0);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (!a_busy) break;
        end
        check_val("t2_busy_idle", 32'(a_busy), 32'd0);

        // Round-robin with both requesters continuously valid
        do_reset();
        base = rec_n[0];
        va = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_grant(0, idx, vec);
            check_val($sformatf("t3_grant%0d", i), 32'(idx), 32'(i % 2));
        end
        va = 2'b00;
        wait_words(0, base + 4);
        for (int i = 0; i < 4; i++)
            check_val($sformatf("t3_word%0d", i), 32'(rec_word[0][base+i]),
                      (i % 2) ? 32'h1123 : 32'h0ABC);
        for (int i = 0; i < 3; i++)
            check_val($sformatf("t3_period%0d", i),
                      32'(rec_fall[0][base+i+1] - rec_fall[0][base+i]), 32'd138);

        // Latch requested mid-word while requester 1 waits; second pulse merges
        do_reset();
        base = rec_n[0];
        lbase = lat_n[0];
        va = 2'b11;
        wait_grant(0, idx, vec);
        check_val("t4_grant0", 32'(idx), 32'd0);
        va = 2'b10;
        repeat (20) @(posedge clk);
        #1 la = 1'b1;
        @(posedge clk);
        #1 la = 1'b0;
        repeat (20) @(posedge clk);
        #1 la = 1'b1;
        @(posedge clk);
        #1 la = 1'b0;
        wait_grant(0, idx, vec);
        check_val("t4_grant1", 32'(idx), 32'd1);
        va = 2'b00;
        wait_words(0, base + 2);
        check_val("t4_word1", 32'(rec_word[0][base+1]), 32'h1123);
        check_val("t4_latch_count", 32'(lat_n[0] - lbase), 32'd1);
        check_val("t4_latch_len", 32'(lat_len[0]), 32'd2);
        check_val("t4_latch_after_csn", 32'(lat_start[0] - rec_rise[0][base]), 32'd5);
        check_val("t4_word1_after_latch", 32'(rec_fall[0][base+1] - rec_rise[0][base]), 32'd9);
        check_val("t4_overlap", 32'(overlap[0]), 32'd0);

        // Reset in the middle of a word
        do_reset();
        va = 2'b01;
        wait_grant(0, idx, vec);
        check_val("t5_grant_pre", 32'(idx), 32'd0);
        va = 2'b00;
        hit = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (cur_bits[0] >= 8) begin
                hit = 1'b1;
                break;
            end
        end
        check_val("t5_reached_bit7", 32'(hit), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("t5_csn_after_rst", 32'(a_csn), 32'd1);
        check_val("t5_sclk_after_rst", 32'(a_sclk), 32'd0);
        check_val("t5_busy_after_rst", 32'(a_busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        base = rec_n[0];
        va = 2'b11;
        wait_grant(0, idx, vec);
        check_val("t5_grant_rr0", 32'(idx), 32'd0);
        check_val("t5_ready", 32'(vec), 32'd1);
        va = 2'b00;
        wait_words(0, base + 1);
        check_val("t5_word", 32'(rec_word[0][base]), 32'h0ABC);
        check_val("t5_bits", 32'(rec_bits[0][base]), 32'd16);
        check_val("t5_csn_low", 32'(rec_len[0][base]), 32'd132);
        check_val("onehot_a", 32'(oh_err[0]), 32'd0);

        // Three requesters at SCLK_DIV=1
        base = rec_n[1];
        vb = 3'b111;
        for (int i = 0; i < 3; i++) begin
            wait_grant(1, idx, vec);
            check_val($sformatf("t6_grant%0d", i), 32'(idx), 32'(i));
            vb[i] = 1'b0;
        end
        vb = 3'b000;
        wait_words(1, base + 3);
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("t6_word%0d", i), 32'(rec_word[1][base+i]),
                      32'((i << 12) | (32'h111 * (i + 1))));
            check_val($sformatf("t6_csn_low%0d", i), 32'(rec_len[1][base+i]), 32'd33);
            check_val($sformatf("t6_sclk_per%0d", i), 32'(rec_per[1][base+i]), 32'd2);
        end
        check_val("onehot_b", 32'(oh_err[1]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
